// File: rtl/alu_share_arb_pkg.sv
// Shared constants for the ALU-sharing arbiter: datapath width, ALU opcode map,
// illegal-opcode sentinels and the round-robin pick helper.
package alu_share_arb_pkg;

    localparam int ARB_XLEN   = 32;
    localparam int ALU_OP_MSB = 3;
    localparam int ARB_OPW    = ALU_OP_MSB + 1;

    localparam logic [ARB_OPW-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ARB_OPW-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ARB_OPW-1:0] ALU_OP_SLL  = 4'd2;
    localparam logic [ARB_OPW-1:0] ALU_OP_SLT  = 4'd3;
    localparam logic [ARB_OPW-1:0] ALU_OP_SLTU = 4'd4;
    localparam logic [ARB_OPW-1:0] ALU_OP_XOR  = 4'd5;
    localparam logic [ARB_OPW-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ARB_OPW-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ARB_OPW-1:0] ALU_OP_OR   = 4'd8;
    localparam logic [ARB_OPW-1:0] ALU_OP_AND  = 4'd9;
    localparam logic [ARB_OPW-1:0] ALU_OP_EQ   = 4'd10;
    localparam logic [ARB_OPW-1:0] ALU_OP_NE   = 4'd11;
    localparam logic [ARB_OPW-1:0] ALU_OP_LT   = 4'd12;
    localparam logic [ARB_OPW-1:0] ALU_OP_GE   = 4'd13;
    localparam logic [ARB_OPW-1:0] ALU_OP_LTU  = 4'd14;
    localparam logic [ARB_OPW-1:0] ALU_OP_GEU  = 4'd15;

    localparam logic [31:0] ALU_ILLEGAL_OP  = 32'hDEADBEEF;
    localparam logic [31:0] ALU_ILLEGAL_CMP = 32'hBADDCAFE;

    typedef enum logic [0:0] {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

    // One-hot pick; on contention the port that did not win last time goes first.
    function automatic logic [1:0] rr_pick(input logic [1:0] elig, input port_e last);
        logic [1:0] g;
        case (elig)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == PORT_1) ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Shared combinational ALU: arithmetic/logic ops, or branch compares when is_cond is set.
// Unsupported opcodes return fixed sentinel patterns.
module ALU
    import alu_share_arb_pkg::*;
#(
    parameter int XLEN = ARB_XLEN,
    parameter int OPW  = ARB_OPW
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            is_cond,
    input  logic [OPW-1:0]  op,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = op2[SHW-1:0];

    // Compare ops produce a single flag in bit 0; everything else is full width.
    always_comb begin
        result = XLEN'(ALU_ILLEGAL_OP);
        if (is_cond) begin
            case (op)
                ALU_OP_EQ:  result = XLEN'(op1 == op2);
                ALU_OP_NE:  result = XLEN'(op1 != op2);
                ALU_OP_LT:  result = XLEN'($signed(op1) < $signed(op2));
                ALU_OP_GE:  result = XLEN'($signed(op1) >= $signed(op2));
                ALU_OP_LTU: result = XLEN'(op1 < op2);
                ALU_OP_GEU: result = XLEN'(op1 >= op2);
                default:    result = XLEN'(ALU_ILLEGAL_CMP);
            endcase
        end else begin
            case (op)
                ALU_OP_ADD:  result = op1 + op2;
                ALU_OP_SUB:  result = op1 - op2;
                ALU_OP_SLL:  result = op1 << shamt_s;
                ALU_OP_SLT:  result = XLEN'($signed(op1) < $signed(op2));
                ALU_OP_SLTU: result = XLEN'(op1 < op2);
                ALU_OP_XOR:  result = op1 ^ op2;
                ALU_OP_SRL:  result = op1 >> shamt_s;
                ALU_OP_SRA:  result = XLEN'($signed(op1) >>> shamt_s);
                ALU_OP_OR:   result = op1 | op2;
                ALU_OP_AND:  result = op1 & op2;
                default:     result = XLEN'(ALU_ILLEGAL_OP);
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant generator; remembers which port won the last accept.
module rr_arb2
    import alu_share_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       accept,
    output logic [1:0] grant
);

    port_e last_grant_q;
    port_e last_grant_d;

    assign grant = rr_pick(elig, last_grant_q);

    always_comb begin
        if (accept) begin
            last_grant_d = grant[1] ? PORT_1 : PORT_0;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Reset to port 1 so port 0 takes the first contended slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT_1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the integer-execute port (0) and the branch-compare port (1);
// results land in a per-port response register one cycle after acceptance.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int XLEN = ARB_XLEN,
    parameter int OPW  = ARB_OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [XLEN-1:0] req_op1_0,
    input  logic [XLEN-1:0] req_op2_0,
    input  logic            req_is_cond_0,
    input  logic [OPW-1:0]  req_op_0,
    output logic            rsp_valid_0,
    input  logic            rsp_ready_0,
    output logic [XLEN-1:0] rsp_result_0,
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [XLEN-1:0] req_op1_1,
    input  logic [XLEN-1:0] req_op2_1,
    input  logic            req_is_cond_1,
    input  logic [OPW-1:0]  req_op_1,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_1,
    output logic [XLEN-1:0] rsp_result_1
);

    logic [1:0]            req_valid_s;
    logic [1:0]            rsp_ready_s;
    logic [1:0]            elig_s;
    logic [1:0]            grant_s;
    logic [1:0]            accept_s;
    logic [XLEN-1:0]       alu_op1_s;
    logic [XLEN-1:0]       alu_op2_s;
    logic                  alu_is_cond_s;
    logic [OPW-1:0]        alu_op_s;
    logic [XLEN-1:0]       alu_result_s;
    logic [1:0]            rsp_valid_q;
    logic [1:0]            rsp_valid_d;
    logic [1:0][XLEN-1:0]  rsp_result_q;
    logic [1:0][XLEN-1:0]  rsp_result_d;

    assign req_valid_s = {req_valid_1, req_valid_0};
    assign rsp_ready_s = {rsp_ready_1, rsp_ready_0};
    // A full response slot only frees up for a new request when it is drained this cycle.
    assign elig_s      = req_valid_s & (~rsp_valid_q | rsp_ready_s);
    assign accept_s    = grant_s & {2{~rst}};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .elig   (elig_s),
        .accept (|accept_s),
        .grant  (grant_s)
    );

    // Without a port-1 grant the ALU sees port 0's operands; the result is ignored then.
    always_comb begin
        if (grant_s[1]) begin
            alu_op1_s     = req_op1_1;
            alu_op2_s     = req_op2_1;
            alu_is_cond_s = req_is_cond_1;
            alu_op_s      = req_op_1;
        end else begin
            alu_op1_s     = req_op1_0;
            alu_op2_s     = req_op2_0;
            alu_is_cond_s = req_is_cond_0;
            alu_op_s      = req_op_0;
        end
    end

    ALU #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) u_alu (
        .op1     (alu_op1_s),
        .op2     (alu_op2_s),
        .is_cond (alu_is_cond_s),
        .op      (alu_op_s),
        .result  (alu_result_s)
    );

    // Accept wins over drain, so a same-cycle drain+accept keeps the slot full.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        for (int i = 0; i < 2; i++) begin
            if (accept_s[i]) begin
                rsp_valid_d[i]  = 1'b1;
                rsp_result_d[i] = alu_result_s;
            end else if (rsp_ready_s[i]) begin
                rsp_valid_d[i]  = 1'b0;
            end else begin
                rsp_valid_d[i]  = rsp_valid_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= {(2*XLEN){1'b0}};
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign req_ready_0  = accept_s[0];
    assign req_ready_1  = accept_s[1];
    assign rsp_valid_0  = rsp_valid_q[0];
    assign rsp_valid_1  = rsp_valid_q[1];
    assign rsp_result_0 = rsp_result_q[0];
    assign rsp_result_1 = rsp_result_q[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed table of arbitration/response scenarios, then randomized traffic
// checked against a cycle-level reference model of the two response slots.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [3:0]  op;
    } pay_t;

    typedef struct {
        logic        rst;
        logic        v0;
        pay_t        p0;
        logic        rr0;
        logic        v1;
        pay_t        p1;
        logic        rr1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rv0;
        logic        e_rv1;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_ready_0, req_is_cond_0, rsp_valid_0, rsp_ready_0;
    logic        req_valid_1, req_ready_1, req_is_cond_1, rsp_valid_1, rsp_ready_1;
    logic [31:0] req_op1_0, req_op2_0, rsp_result_0;
    logic [31:0] req_op1_1, req_op2_1, rsp_result_1;
    logic [3:0]  req_op_0, req_op_1;

    int checks = 0;
    int errors = 0;

    // Reference model state: response slots and who won the last accept
    int          m_last = 1;
    logic        m_vld [2];
    logic [31:0] m_res [2];
    logic        m_acc [2];

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op1_0(req_op1_0),
        .req_op2_0(req_op2_0), .req_is_cond_0(req_is_cond_0), .req_op_0(req_op_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_result_0(rsp_result_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op1_1(req_op1_1),
        .req_op2_1(req_op2_1), .req_is_cond_1(req_is_cond_1), .req_op_1(req_op_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_result_1(rsp_result_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic pay_t mkp(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic [3:0] op);
        pay_t p;
        p.a = a; p.b = b; p.c = c; p.op = op;
        return p;
    endfunction

    function automatic vec_t mkv(input logic r, input logic v0, input pay_t p0, input logic rr0,
                                 input logic v1, input pay_t p1, input logic rr1,
                                 input logic rdy0, input logic rdy1, input logic rv0, input logic rv1,
                                 input logic [31:0] r0, input logic [31:0] r1);
        vec_t t;
        t.rst = r; t.v0 = v0; t.p0 = p0; t.rr0 = rr0; t.v1 = v1; t.p1 = p1; t.rr1 = rr1;
        t.e_rdy0 = rdy0; t.e_rdy1 = rdy1; t.e_rv0 = rv0; t.e_rv1 = rv1; t.e_r0 = r0; t.e_r1 = r1;
        return t;
    endfunction

    // Behavioural ALU straight from the opcode table
    function automatic logic [31:0] ref_alu(input pay_t p);
        int unsigned sh;
        sh = p.b % 32;
        if (p.c) begin
            case (p.op)
                4'd10:   return {31'd0, p.a == p.b};
                4'd11:   return {31'd0, p.a != p.b};
                4'd12:   return {31'd0, $signed(p.a) < $signed(p.b)};
                4'd13:   return {31'd0, $signed(p.a) >= $signed(p.b)};
                4'd14:   return {31'd0, p.a < p.b};
                4'd15:   return {31'd0, p.a >= p.b};
                default: return 32'hBADDCAFE;
            endcase
        end
        case (p.op)
            4'd0:    return p.a + p.b;
            4'd1:    return p.a - p.b;
            4'd2:    return p.a << sh;
            4'd3:    return {31'd0, $signed(p.a) < $signed(p.b)};
            4'd4:    return {31'd0, p.a < p.b};
            4'd5:    return p.a ^ p.b;
            4'd6:    return p.a >> sh;
            4'd7:    return $signed(p.a) >>> sh;
            4'd8:    return p.a | p.b;
            4'd9:    return p.a & p.b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic drive(input logic r, input logic v0, input pay_t p0, input logic rr0,
                         input logic v1, input pay_t p1, input logic rr1);
        rst = r;
        req_valid_0 = v0; req_op1_0 = p0.a; req_op2_0 = p0.b; req_is_cond_0 = p0.c; req_op_0 = p0.op;
        rsp_ready_0 = rr0;
        req_valid_1 = v1; req_op1_1 = p1.a; req_op2_1 = p1.b; req_is_cond_1 = p1.c; req_op_1 = p1.op;
        rsp_ready_1 = rr1;
    endtask

    // Called at the negedge: optionally compare, then advance the model across the posedge.
    task automatic model_cycle(input bit chk);
        bit   e0, e1;
        int   win;
        pay_t p [2];
        logic rr [2];
        p[0] = mkp(req_op1_0, req_op2_0, req_is_cond_0, req_op_0);
        p[1] = mkp(req_op1_1, req_op2_1, req_is_cond_1, req_op_1);
        rr[0] = rsp_ready_0;
        rr[1] = rsp_ready_1;
        e0 = req_valid_0 && (!m_vld[0] || rsp_ready_0);
        e1 = req_valid_1 && (!m_vld[1] || rsp_ready_1);
        if (rst)           win = -1;
        else if (e0 && e1) win = 1 - m_last;
        else if (e0)       win = 0;
        else if (e1)       win = 1;
        else               win = -1;
        if (chk) begin
            check("m_rdy0", {31'd0, req_ready_0}, {31'd0, win == 0});
            check("m_rdy1", {31'd0, req_ready_1}, {31'd0, win == 1});
            check("m_rv0", {31'd0, rsp_valid_0}, {31'd0, m_vld[0]});
            check("m_rv1", {31'd0, rsp_valid_1}, {31'd0, m_vld[1]});
            check("m_res0", rsp_result_0, m_res[0]);
            check("m_res1", rsp_result_1, m_res[1]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 1'b0;
            if (rst) begin
                m_vld[i] = 1'b0;
                m_res[i] = 32'd0;
            end else if (win == i) begin
                m_vld[i] = 1'b1;
                m_res[i] = ref_alu(p[i]);
                m_acc[i] = 1'b1;
            end else if (rr[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        if (rst) m_last = 1;
        else if (win >= 0) m_last = win;
        #1;
    endtask

    initial begin
        pay_t P_NONE, P_ADD57, P_SUB35, P_SLL14, P_EQ99, P_EQ98, P_CADD, P_BAD, P_ADD11;
        vec_t tbl [22];
        pay_t rp [2];
        logic rv [2];

        P_NONE  = mkp(32'd0, 32'd0, 1'b0, 4'd0);
        P_ADD57 = mkp(32'd5, 32'd7, 1'b0, 4'd0);
        P_SUB35 = mkp(32'd3, 32'd5, 1'b0, 4'd1);
        P_SLL14 = mkp(32'd1, 32'd4, 1'b0, 4'd2);
        P_EQ99  = mkp(32'd9, 32'd9, 1'b1, 4'd10);
        P_EQ98  = mkp(32'd9, 32'd8, 1'b1, 4'd10);
        P_CADD  = mkp(32'd1, 32'd2, 1'b1, 4'd0);
        P_BAD   = mkp(32'd1, 32'd2, 1'b0, 4'd12);
        P_ADD11 = mkp(32'd1, 32'd1, 1'b0, 4'd0);

        //                rst v0 p0       rr0 v1 p1      rr1  rdy0 rdy1 rv0 rv1 res0          res1
        tbl[0]  = mkv(1'b1, 1'b1, P_ADD57, 1'b0, 1'b1, P_EQ99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[1]  = mkv(1'b1, 1'b1, P_ADD57, 1'b0, 1'b1, P_EQ99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[2]  = mkv(1'b0, 1'b1, P_ADD57, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[3]  = mkv(1'b0, 1'b1, P_SUB35, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 32'd0);
        tbl[4]  = mkv(1'b0, 1'b1, P_SUB35, 1'b1, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd12, 32'd1);
        tbl[5]  = mkv(1'b0, 1'b1, P_ADD57, 1'b1, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd1);
        tbl[6]  = mkv(1'b0, 1'b1, P_SUB35, 1'b1, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12, 32'd1);
        tbl[7]  = mkv(1'b0, 1'b0, P_NONE,  1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd1);
        tbl[8]  = mkv(1'b0, 1'b1, P_SLL14, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd1);
        tbl[9]  = mkv(1'b0, 1'b1, P_SLL14, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd16, 32'd1);
        tbl[10] = mkv(1'b0, 1'b1, P_SLL14, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd16, 32'd1);
        tbl[11] = mkv(1'b0, 1'b1, P_SLL14, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd16, 32'd1);
        tbl[12] = mkv(1'b0, 1'b1, P_SLL14, 1'b1, 1'b1, P_EQ98, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd16, 32'd1);
        tbl[13] = mkv(1'b0, 1'b1, P_ADD57, 1'b1, 1'b1, P_EQ98, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd16, 32'd1);
        tbl[14] = mkv(1'b0, 1'b0, P_NONE,  1'b1, 1'b1, P_EQ98, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 32'd1);
        tbl[15] = mkv(1'b0, 1'b0, P_NONE,  1'b1, 1'b1, P_CADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd12, 32'd0);
        tbl[16] = mkv(1'b0, 1'b1, P_BAD,   1'b1, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd12, 32'hBADDCAFE);
        tbl[17] = mkv(1'b0, 1'b1, P_ADD57, 1'b1, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hBADDCAFE);
        tbl[18] = mkv(1'b1, 1'b1, P_ADD11, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd12, 32'hBADDCAFE);
        tbl[19] = mkv(1'b0, 1'b1, P_ADD11, 1'b1, 1'b1, P_EQ99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[20] = mkv(1'b0, 1'b0, P_NONE,  1'b1, 1'b1, P_EQ99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0);
        tbl[21] = mkv(1'b0, 1'b0, P_NONE,  1'b1, 1'b0, P_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd1);

        // Flush X state before the checked reset cycles
        drive(1'b1, 1'b1, P_ADD57, 1'b0, 1'b1, P_EQ99, 1'b0);
        @(negedge clk);
        model_cycle(1'b0);

        for (int k = 0; k < 22; k++) begin
            drive(tbl[k].rst, tbl[k].v0, tbl[k].p0, tbl[k].rr0, tbl[k].v1, tbl[k].p1, tbl[k].rr1);
            @(negedge clk);
            check($sformatf("t%0d_rdy0", k), {31'd0, req_ready_0}, {31'd0, tbl[k].e_rdy0});
            check($sformatf("t%0d_rdy1", k), {31'd0, req_ready_1}, {31'd0, tbl[k].e_rdy1});
            check($sformatf("t%0d_rv0", k), {31'd0, rsp_valid_0}, {31'd0, tbl[k].e_rv0});
            check($sformatf("t%0d_rv1", k), {31'd0, rsp_valid_1}, {31'd0, tbl[k].e_rv1});
            check($sformatf("t%0d_res0", k), rsp_result_0, tbl[k].e_r0);
            check($sformatf("t%0d_res1", k), rsp_result_1, tbl[k].e_r1);
            model_cycle(1'b0);
        end

        // Random traffic; a pending request keeps its payload until accepted
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rp[0] = P_NONE;
        rp[1] = P_NONE;
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] || m_acc[i]) begin
                    rv[i]    = ($urandom_range(0, 3) != 0);
                    rp[i].a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                    rp[i].b  = ($urandom_range(0, 3) == 0) ? rp[i].a : $urandom;
                    rp[i].c  = 1'($urandom_range(0, 1));
                    rp[i].op = 4'($urandom_range(0, 15));
                end
            end
            drive(r, rv[0], rp[0], 1'($urandom_range(0, 3) != 0),
                  rv[1], rp[1], 1'($urandom_range(0, 3) != 0));
            @(negedge clk);
            model_cycle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter that shares the single combinational `ALU` instance between two requesters (port 0: integer execute path, port 1: branch-compare path). It accepts one operation per cycle through valid/ready handshakes, drives the winner's operands into the ALU, and captures the result in a per-port response register. Each result is returned on the owning port one cycle after acceptance.

## Interface

Parameters:
- `XLEN`: default `` `XLEN `` (32). Operand and result width.
- `OPW`: default `` `ALU_OP_MSB+1 ``. ALU opcode width.

Ports (`i` = 0, 1; every port below exists once per index):
- `clk`  in  1  Clock. The block has one clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `req_valid_i`  in  1  Port i presents an operation.
- `req_ready_i`  out  1  Port i operation is accepted this cycle.
- `req_op1_i`, `req_op2_i`  in  XLEN  Operands.
- `req_is_cond_i`  in  1  Compare (branch-condition) operation.
- `req_op_i`  in  OPW  ALU opcode, using the `` `ALU_OP_* `` encodings.
- `rsp_valid_i`  out  1  Port i result is available.
- `rsp_ready_i`  in  1  Port i consumes its result.
- `rsp_result_i`  out  XLEN  Registered ALU result.

## Operation

- **Eligibility:** `elig_i = req_valid_i & (~rsp_valid_i | rsp_ready_i)`. A port is eligible only if its response slot is empty or is being drained this cycle.
- **Grant:**
  - If only one port is eligible, it wins.
  - If both are eligible, the winner is the port other than `last_grant`.
  - If neither is eligible, there is no grant.
- **Ready:** `req_ready_i = grant_i & ~rst`. Ready depends on the other port's valid. Requesters must not make `req_valid` depend on `req_ready`.
- **Payload hold:** once `req_valid_i` is asserted, it and its payload are held until the handshake completes. The arbiter may deassert ready while valid is held (the port lost arbitration).
- **ALU drive:** the ALU inputs are muxed from the granted port. When there is no grant, port 0's payload is driven; the result is ignored.
- **On accept** (`req_valid_i & req_ready_i`):
  - `rsp_result_i <= alu_result`, `rsp_valid_i <= 1`.
  - `last_grant <= i`.
- **On drain without a new accept** (`rsp_valid_i & rsp_ready_i` and no accept on port i): `rsp_valid_i <= 0`. `rsp_result_i` holds its last value.
- **Simultaneous drain and accept on the same port:** `rsp_valid_i` stays 1 and the result is replaced by the new value.
- **Results are passed through unmodified**, including the ALU's illegal-opcode sentinels (0xdeadbeef, 0xbaddcafe). Compare results are 0 or 1 in bit 0.
- **Fairness:** with both ports continuously eligible, grants strictly alternate. No port waits more than one cycle while eligible.
- **Reset (may arrive mid-operation):**
  - `rsp_valid_0/1 = 0`, `rsp_result_0/1 = 0`.
  - `last_grant = 1`, so port 0 wins the first contention.
  - `req_ready_0/1 = 0` while `rst` is high.
  - An accept that coincides with `rst` is discarded.

## Timing

- Latency: accept in cycle N gives `rsp_valid` high in cycle N+1, with the result stable while it waits.
- Throughput: one operation per cycle in aggregate. A single port sustains one per cycle when its `rsp_ready` is held high.
- Backpressure: if `rsp_ready_i` is low and `rsp_valid_i` is high, port i is ineligible. The other port may still use the ALU.
- Critical path: request mux, then ALU, then response register. There are no outputs that combinationally depend on `rsp_*` data.
- `req_ready_i` is combinational from `req_valid_*`, `rsp_valid_*`, `rsp_ready_*`, `last_grant` and `rst`.

## Structure

- `` `XLEN ``, `` `XBUS ``, `` `ALU_OP_MSB `` and the `` `ALU_OP_* `` codes come from the shared `defs.v`. Nothing new is added there.
- Instantiate the existing `ALU` unchanged.
- Factor grant logic into one sub-module, `rr_arb2`:
  - inputs: `clk`, `rst`, `elig[1:0]`, `accept`;
  - outputs: `grant[1:0]`;
  - holds `last_grant` state.
- Response slots are two identical register sets inside the top block.

## Test plan

- **Reset:** assert `rst` for 2 cycles with both `req_valid` high. Expect `req_ready_0/1 = 0` and `rsp_valid_0/1 = 0` throughout. In the first cycle after reset, port 0 is granted.
- **Single port:** port 0 sends ADD 5 + 7. The next cycle shows `rsp_valid_0 = 1`, `rsp_result_0 = 12`. Then a back-to-back SUB 3 − 5 with `rsp_ready_0 = 1` gives 0xFFFFFFFE one cycle later.
- **Contention:** both ports valid for 4 cycles, both `rsp_ready` high (port 0 SLL 1 << 4, port 1 EQ compare 9 == 9). Grants alternate 0, 1, 0, 1. Results are 16 on port 0 and 1 on port 1.
- **Backpressure:**
  - Hold `rsp_ready_1 = 0` with `rsp_valid_1` high. Port 1 `req_ready` stays 0 and port 0 is granted every cycle.
  - Raise `rsp_ready_1`. Port 1 drains and is accepted in the same cycle, and `rsp_valid_1` stays 1.
- **Sentinels:** port 1 sends `is_cond = 1` with opcode ADD. `rsp_result_1 = 0xbaddcafe`. An unused non-cond opcode gives `0xdeadbeef`.
- **Mid-operation reset:** assert `rst` in the cycle after an accept. `rsp_valid` drops to 0 and `last_grant = 1`. Arbitration then restarts with port 0.
